// File: rtl/cmd_intf_pkg.sv
// Shared definitions for the command interface: demux sizing defaults,
// collector state encoding and the canned error/timeout read data.
package cmd_intf_pkg;

  // Demux-side defaults shared by the demux and the response collector
  localparam int          DEMUX_NUM_TARGETS  = 8;
  localparam int          HOST_DATA_BITS_DEF = 32;

  // Read data returned when a target never answers or the select is illegal
  localparam logic [31:0] TIMEOUT_RDATA_DEF  = 32'hDEAD_BEEF;

  // Width of the wait counter and of the timeout statistics counter
  localparam int          TO_CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } coll_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    return (&v) ? v : v + TO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot checker plus binary index encoder for the target select lines.
// valid: exactly one bit set; multi: two or more bits set.
module onehot_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     sel,
  output logic             valid,
  output logic             multi,
  output logic [IDX_W-1:0] index
);

  logic any;

  // Clearing the lowest set bit leaves something only if two or more were set
  assign any   = |sel;
  assign multi = |(sel & (sel - N'(1)));
  assign valid = any & ~multi;

  // OR together the indices of set bits; exact whenever valid is high
  always_comb begin
    index = '0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) index = index | IDX_W'(k);
    end
  end

endmodule

// File: rtl/cmd_resp_collector.sv
// Collects the response of the selected target for one command, with a
// wait-for-ack timeout and multi-select error handling. Exactly one o_ack
// is produced per select assertion (none if the select is withdrawn early).
module cmd_resp_collector
  import cmd_intf_pkg::*;
#(
  parameter int NUM_TARGETS    = DEMUX_NUM_TARGETS,
  parameter int HOST_DATA_BITS = HOST_DATA_BITS_DEF,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [HOST_DATA_BITS-1:0] TIMEOUT_RDATA = HOST_DATA_BITS'(TIMEOUT_RDATA_DEF)
) (
  input  logic                                  i_sys_clk,
  input  logic                                  i_sys_rst_n,
  input  logic [NUM_TARGETS-1:0]                i_select_lines,
  input  logic                                  i_rd_wr_n,
  input  logic [NUM_TARGETS-1:0]                i_tgt_ack,
  input  logic [NUM_TARGETS*HOST_DATA_BITS-1:0] i_tgt_rdata,
  output logic                                  o_ack,
  output logic [HOST_DATA_BITS-1:0]             o_rdata,
  output logic                                  o_timeout,
  output logic                                  o_sel_err,
  output logic [TO_CNT_W-1:0]                   o_timeout_count
);

  localparam int IDX_W = $clog2(NUM_TARGETS);
  localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  // Per-target view of the flat read-data bus
  logic [NUM_TARGETS-1:0][HOST_DATA_BITS-1:0] tgt_rdata;
  assign tgt_rdata = i_tgt_rdata;

  logic             enc_valid;
  logic             enc_multi;
  logic [IDX_W-1:0] enc_idx;

  onehot_encoder #(
    .N     (NUM_TARGETS),
    .IDX_W (IDX_W)
  ) u_enc (
    .sel   (i_select_lines),
    .valid (enc_valid),
    .multi (enc_multi),
    .index (enc_idx)
  );

  coll_state_e               state_q,   state_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic                      rd_q,      rd_d;
  logic [TO_CNT_W-1:0]       cnt_q,     cnt_d;
  // Response staged in WAIT, published together with o_ack from RESP
  logic [HOST_DATA_BITS-1:0] hold_q,    hold_d;
  logic                      to_pend_q, to_pend_d;
  logic                      ack_q,     ack_d;
  logic [HOST_DATA_BITS-1:0] rdata_q,   rdata_d;
  logic                      timeout_q, timeout_d;
  logic                      sel_err_q, sel_err_d;
  logic [TO_CNT_W-1:0]       to_cnt_q,  to_cnt_d;

  // Next-state and output logic; pulses default low, data holds
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    to_pend_d = to_pend_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    sel_err_d = 1'b0;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_multi) begin
          // Illegal select: answer immediately with the error pattern
          rdata_d   = TIMEOUT_RDATA;
          ack_d     = 1'b1;
          sel_err_d = 1'b1;
          state_d   = ST_RELEASE;
        end else if (enc_valid) begin
          idx_d   = enc_idx;
          rd_d    = i_rd_wr_n;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ack beats both abort and a same-cycle timeout
        if (i_tgt_ack[idx_q]) begin
          hold_d    = rd_q ? tgt_rdata[idx_q] : '0;
          to_pend_d = 1'b0;
          state_d   = ST_RESP;
        end else if (!i_select_lines[idx_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          hold_d    = TIMEOUT_RDATA;
          to_pend_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      ST_RESP: begin
        ack_d     = 1'b1;
        rdata_d   = hold_q;
        timeout_d = to_pend_q;
        if (to_pend_q) to_cnt_d = sat_inc(to_cnt_q);
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: begin
        // One ack per select assertion: wait for the bus to go idle
        if (!(|i_select_lines)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      to_pend_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      sel_err_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      to_pend_q <= to_pend_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      sel_err_q <= sel_err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign o_ack           = ack_q;
  assign o_rdata         = rdata_q;
  assign o_timeout       = timeout_q;
  assign o_sel_err       = sel_err_q;
  assign o_timeout_count = to_cnt_q;

endmodule

// File: doc/cmd_resp_collector.md
CMD_RESP_COLLECTOR -- requirements
Module: cmd_resp_collector

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 8, the number of one-hot target select lines.
REQ-002 SHALL have parameter HOST_DATA_BITS, default 32, the read-data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, the wait-for-ack limit in clocks (legal range 2..65535).
REQ-004 SHALL have parameter TIMEOUT_RDATA, default 32'hDEAD_BEEF, the read data returned on timeout or error.
REQ-005 SHALL have one clock and asynchronous active-low reset: i_sys_clk  input  1  system clock.
REQ-006 i_sys_rst_n  input  1  async active-low reset.
REQ-007 i_select_lines  input  NUM_TARGETS  one-hot target selects from the upstream demux.
REQ-008 i_rd_wr_n  input  1  1=read, 0=write, valid while any select is high.
REQ-009 i_tgt_ack  input  NUM_TARGETS  per-target ack pulse.
REQ-010 i_tgt_rdata  input  NUM_TARGETS*HOST_DATA_BITS  per-target read data, target k at bits [k*W +: W].
REQ-011 o_ack  output  1  single-cycle ack toward the command memory interface.
REQ-012 o_rdata  output  HOST_DATA_BITS  response read data, valid with o_ack and held until the next ack.
REQ-013 o_timeout  output  1  one-cycle pulse coincident with a timeout ack.
REQ-014 o_sel_err  output  1  one-cycle pulse coincident with a multi-select error ack.
REQ-015 o_timeout_count  output  16  saturating count of timeouts since reset.

Function
REQ-016 SHALL implement the states IDLE, WAIT, RESP and RELEASE.
REQ-017 IDLE: exactly one select bit high -> latch its index and i_rd_wr_n, clear the wait counter, go to WAIT.
REQ-018 IDLE: more than one select bit high -> load TIMEOUT_RDATA, pulse o_sel_err with o_ack on the next cycle, go to RELEASE.
REQ-019 IDLE: all select bits low -> stay in IDLE and ignore all i_tgt_ack.
REQ-020 WAIT: i_tgt_ack[idx] high -> capture o_rdata, go to RESP.
- Read: o_rdata = i_tgt_rdata[idx].
- Write: o_rdata = 0.
REQ-021 WAIT: acks from non-selected targets SHALL be ignored.
REQ-022 WAIT: the counter increments each cycle; counter == TIMEOUT_CYCLES-1 with no ack -> o_rdata = TIMEOUT_RDATA, o_timeout pulse, o_timeout_count +1 (saturating at 16'hFFFF), go to RESP.
REQ-023 Ack and timeout in the same cycle: the ack SHALL win, with no timeout pulse and no count increment.
REQ-024 WAIT: select[idx] deasserted before any ack -> abort to IDLE, with no o_ack and no count change.
REQ-025 RESP: o_ack SHALL be high for exactly one cycle, then go to RELEASE.
REQ-026 Latency: o_ack SHALL assert exactly 2 cycles after the cycle in which i_tgt_ack[idx] is sampled high.
REQ-027 RELEASE: stay until all select bits are low, then go to IDLE; no second ack is issued per select assertion.
REQ-028 Unreachable or unknown state encodings SHALL return to IDLE.

Reset
REQ-029 Asynchronous assertion, synchronous deassertion handled by the external reset synchronizer.
REQ-030 Reset values: state IDLE, o_ack 0, o_rdata 0, o_timeout 0, o_sel_err 0, o_timeout_count 0, wait counter 0, latched index 0.
REQ-031 Reset mid-transaction SHALL drop the transaction; no ack is issued after reset release unless a new select arrives.

Structure
REQ-032 The state enum and the TIMEOUT_RDATA default SHALL live in the shared cmd_intf_pkg, alongside the demux definitions.
REQ-033 One-hot validation plus index encoding SHALL be one sub-module, onehot_encoder, providing outputs valid, multi and index[$clog2(NUM_TARGETS)-1:0].
REQ-034 All outputs SHALL be driven directly from flops.

Verification
REQ-035 Read: select=8'h04; ack[2] after 3 cycles with rdata[2]=32'h1234_5678 -> o_ack pulse 2 cycles later, o_rdata=32'h1234_5678.
REQ-036 Write: select=8'h80, rd_wr_n=0; ack[7] -> o_ack with o_rdata=0.
REQ-037 Timeout: TIMEOUT_CYCLES=16, select=8'h01, no ack -> o_ack, o_timeout and o_rdata=32'hDEAD_BEEF together; o_timeout_count=1.
REQ-038 Multi-select: select=8'h03 -> o_sel_err and o_ack next cycle; no further ack until select returns to 0.
REQ-039 Stray and abort: ack[5] while selected target is 1 -> ignored; select dropped before ack -> no o_ack; next transaction succeeds.
REQ-040 Ack/timeout collision and reset: ack on cycle TIMEOUT_CYCLES-1 -> normal ack, count unchanged; i_sys_rst_n low during WAIT -> all outputs 0 and no late ack.
